md_scheduler: RTL and testbench

Sequencing controller for the pipeline's multiply/divide resource. It accepts mult/multu/div/divu/mthi/mtlo issues from the E stage, latches the operands and runs a fixed-latency busy countdown. At the end of the countdown it commits results to the HI/LO registers it owns. It also generates the D-stage stall for any multiply/divide-class instruction that would collide with an operation in flight, replacing the loose `start`/`busy` handling in the hazard logic.

---
 rtl/md_pkg.sv | 22 ++
 rtl/md_core.sv | 62 ++++++
 rtl/md_scheduler.sv | 127 ++++++++++++
 tb/tb_md_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings,
// controller states and default busy-cycle counts.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    function automatic int md_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath. Works on the operands latched by
// md_scheduler and produces the HI/LO results plus a divide-by-zero flag.
module md_core
    import md_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [31:0] o_hi_res,
    output logic [31:0] o_lo_res,
    output logic        o_div0
);

    logic        [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_divisor;
    logic signed [32:0] w_sdividend;
    logic signed [32:0] w_sdivisor;
    logic        [31:0] w_squot;
    logic        [31:0] w_srem;
    logic        [31:0] w_uquot;
    logic        [31:0] w_urem;

    assign o_div0 = i_op[1] && (i_rt == 32'd0);

    // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
    assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    // A zero divisor is swapped for 1 so the dividers never produce x; the
    // scheduler discards the result when o_div0 is set.
    assign w_divisor = (i_rt == 32'd0) ? 32'd1 : i_rt;

    // 33-bit signed division keeps 0x80000000 / -1 from overflowing the
    // divider; the low 32 bits give the architectural wrap-around result.
    assign w_sdividend = $signed({i_rs[31], i_rs});
    assign w_sdivisor  = $signed({w_divisor[31], w_divisor});
    assign w_squot     = 32'(w_sdividend / w_sdivisor);
    assign w_srem      = 32'(w_sdividend % w_sdivisor);
    assign w_uquot     = i_rs / w_divisor;
    assign w_urem      = i_rs % w_divisor;

    // Select the result pair for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        o_hi_res = w_urem;
        o_lo_res = w_uquot;
        case (i_op)
            MD_MULT:  {o_hi_res, o_lo_res} = w_prod_s;
            MD_MULTU: {o_hi_res, o_lo_res} = w_prod_u;
            MD_DIV: begin
                o_hi_res = w_srem;
                o_lo_res = w_squot;
            end
            default: begin
                o_hi_res = w_urem;
                o_lo_res = w_uquot;
            end
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide sequencing controller. Latches operands from E, runs a
// fixed-latency busy countdown, commits HI/LO and raises the D-stage stall.
// Optional feature: define MD_DIV0_SKIP_EN to finish a divide by zero after
// a single busy cycle instead of the full divide latency.
module md_scheduler
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_e,
    input  logic [1:0]  md_op_e,
    input  logic        hl_we_e,
    input  logic        hl_sel_e,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        md_use_d,
    output logic        busy,
    output logic        md_done,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);

    md_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]   r_op;
    logic [31:0]  r_rs;
    logic [31:0]  r_rt;
    logic [31:0]  r_hi;
    logic [31:0]  r_lo;
    logic         r_busy;
    logic         r_md_done;

    logic [CNT_W-1:0] w_load_cnt;
    logic [31:0]  w_hi_res;
    logic [31:0]  w_lo_res;
    logic         w_div0;

    md_core u_core (
        .i_op     (r_op),
        .i_rs     (r_rs),
        .i_rt     (r_rt),
        .o_hi_res (w_hi_res),
        .o_lo_res (w_lo_res),
        .o_div0   (w_div0)
    );

    // Countdown start value for the operation being issued this cycle.
    always_comb begin
        w_load_cnt = md_op_e[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
`ifdef MD_DIV0_SKIP_EN
        if (md_op_e[1] && (rt_e == 32'd0)) begin
            w_load_cnt = '0;
        end
`endif
    end

    // Controller FSM: issue, countdown, commit, and direct mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_op      <= MD_MULT;
            r_rs      <= '0;
            r_rt      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
            r_md_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (start_e) begin
                        r_op    <= md_op_e;
                        r_rs    <= rs_e;
                        r_rt    <= rt_e;
                        r_cnt   <= w_load_cnt;
                        r_busy  <= 1'b1;
                        r_state <= MD_RUN;
                    end else if (hl_we_e) begin
                        if (hl_sel_e) begin
                            r_hi <= rs_e;
                        end else begin
                            r_lo <= rs_e;
                        end
                    end
                end
                MD_RUN: begin
                    if (r_cnt == '0) begin
                        if (!w_div0) begin
                            r_hi <= w_hi_res;
                            r_lo <= w_lo_res;
                        end
                        r_md_done <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= MD_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign md_done  = r_md_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stall_md = md_use_d & (start_e | r_busy);

    // Issues while an operation is in flight are dropped; flag them in simulation.
    a_no_issue_while_busy: assert property (
        @(posedge clk) disable iff (rst) r_busy |-> !(start_e || hl_we_e));

    // start_e and hl_we_e together is an upstream decode error.
    a_no_dual_issue: assert property (
        @(posedge clk) disable iff (rst) !(start_e && hl_we_e));

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed cases plus random issues,
// with a queue of expected HI/LO commits consumed whenever md_done pulses.
module tb_md_scheduler;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MD_DIV0_SKIP_EN
    localparam int DIV0_LEN = 1;
`else
    localparam int DIV0_LEN = DC;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_e;
    logic [1:0]  md_op_e;
    logic        hl_we_e;
    logic        hl_sel_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic        busy;
    logic        md_done;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_e  (start_e),
        .md_op_e  (md_op_e),
        .hl_we_e  (hl_we_e),
        .hl_sel_e (hl_sel_e),
        .rs_e     (rs_e),
        .rt_e     (rt_e),
        .md_use_d (md_use_d),
        .busy     (busy),
        .md_done  (md_done),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] old);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     q;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            MD_MULT:  return sa * sb;
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 32'd0) return old;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return old;
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic int busy_len(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return MC;
        return (b == 32'd0) ? DIV0_LEN : DC;
    endfunction

    // Monitor: every md_done must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (md_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("md_done_unexpected", 64'(md_done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_hilo", {hi, lo}, e);
                end
            end
        end
    end

    // Issue one mult/div at the current cycle and follow it to completion.
    // Entered and left just after a falling edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d);
        logic [63:0] e;
        int n;
        start_e  = 1'b1;
        md_op_e  = op;
        rs_e     = a;
        rt_e     = b;
        md_use_d = use_d;
        #1 check("stall_start_cycle", 64'(stall_md), 64'(use_d));
        e = ref_md(op, a, b, {m_hi, m_lo});
        exp_q.push_back(e);
        {m_hi, m_lo} = e;
        n = busy_len(op, b);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            start_e = 1'b0;
            rs_e    = $urandom;
            rt_e    = $urandom;
            md_op_e = 2'($urandom);
            #1;
            check("busy_during_run", 64'(busy), 64'd1);
            check("md_done_during_run", 64'(md_done), 64'd0);
            check("stall_during_run", 64'(stall_md), 64'(use_d));
        end
        @(negedge clk);
        #1;
        check("busy_after_run", 64'(busy), 64'd0);
        check("md_done_pulse", 64'(md_done), 64'd1);
        check("stall_after_run", 64'(stall_md), 64'd0);
        check("hilo_after_run", {hi, lo}, e);
        md_use_d = 1'b0;
    endtask

    // mthi/mtlo in idle; value must be visible one cycle later.
    task automatic mt(input logic sel, input logic [31:0] val);
        hl_we_e  = 1'b1;
        hl_sel_e = sel;
        rs_e     = val;
        @(negedge clk);
        hl_we_e = 1'b0;
        if (sel) m_hi = val;
        else     m_lo = val;
        #1;
        check("mt_hilo", {hi, lo}, {m_hi, m_lo});
        check("mt_no_busy", 64'(busy), 64'd0);
        check("mt_no_done", 64'(md_done), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_done", 64'(md_done), 64'd0);
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1; start_e = 1'b0; md_op_e = MD_MULT; hl_we_e = 1'b0; hl_sel_e = 1'b0;
        rs_e = '0; rt_e = '0; md_use_d = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(md_done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        md_use_d = 1'b1;
        #1 check("rst_stall_idle", 64'(stall_md), 64'd0);
        start_e = 1'b1;
        #1 check("rst_stall_start", 64'(stall_md), 64'd1);
        start_e = 1'b0; md_use_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Directed cases from the feature list.
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
        check("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_max_x2", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg7_by2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        issue(MD_DIVU, 32'h1234_5678, 32'd0, 1'b1);
        check("divu_by_zero_keeps", {hi, lo}, 64'h0000_0011_0000_0022);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Reset on the third busy cycle of a div aborts it with no commit.
        idle(1);
        start_e = 1'b1; md_op_e = MD_DIV; rs_e = 32'd100; rt_e = 32'd7;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start_e = 1'b0;
            #1 check("abort_busy", 64'(busy), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy_clear", 64'(busy), 64'd0);
        check("abort_hilo_clear", {hi, lo}, 64'd0);
        check("abort_no_done", 64'(md_done), 64'd0);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        idle(DC + 2);
        issue(MD_MULT, 32'd7, 32'hFFFF_FFFE, 1'b1);

        // Randomised mix, including back-to-back issues and idle gaps.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                mt(1'($urandom), $urandom);
            end else begin
                op = 2'($urandom);
                a  = $urandom;
                case ($urandom_range(0, 7))
                    0, 1:    b = 32'd0;
                    2:       b = 32'($urandom_range(1, 9));
                    3:       b = 32'hFFFF_FFFF;
                    default: b = $urandom;
                endcase
                issue(op, a, b, 1'($urandom));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
